// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// Register scoreboard for an in-order issue stage. It tracks destination
// registers of long-latency writes (loads, mul/div) that have been issued but
// not yet written back, and stalls issue on RAW/WAW hazards against them, on
// capacity exhaustion, and for serializing instructions (CSR, fence) until the
// scoreboard has drained.
//
// Parameters
//   MAX_OUTSTANDING  maximum number of in-flight long-latency writes (1..7)
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous reset, active low
//   issue_valid     decoded instruction present at issue
//   read_enable_1   source 1 used
//   read_index_1    source 1 register
//   read_enable_2   source 2 used
//   read_index_2    source 2 register
//   write_enable    destination written (already 0 for x0)
//   write_index     destination register
//   long_latency    result returns later through the completion port
//   serialize       instruction requires an empty scoreboard
//   complete_valid  long-latency result written back this cycle
//   complete_index  register written back
//   flush           synchronous pipeline flush
//   issue_ready     issue permitted this cycle (combinational)
//   busy_mask       registered pending-write bit per register
//   outstanding     registered count of in-flight long-latency writes
//   drain_active    FSM is in DRAIN
//   err_unexpected  one-cycle registered pulse on completion to a non-busy reg
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        read_enable_1,
  input  logic [4:0]  read_index_1,
  input  logic        read_enable_2,
  input  logic [4:0]  read_index_2,
  input  logic        write_enable,
  input  logic [4:0]  write_index,
  input  logic        long_latency,
  input  logic        serialize,
  input  logic        complete_valid,
  input  logic [4:0]  complete_index,
  input  logic        flush,
  output logic        issue_ready,
  output logic [31:0] busy_mask,
  output logic [2:0]  outstanding,
  output logic        drain_active,
  output logic        err_unexpected
);

  localparam logic [2:0] MaxOut = 3'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] busy_q, busy_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic        err_q, err_d;

  logic hazard_raw_1, hazard_raw_2, hazard_waw;
  logic block_capacity, block_serialize, block_state;
  logic accept;
  logic do_set, do_clear;

  // ---------------------------------------------------------------------------
  // Issue gating
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard_raw_1    = read_enable_1 & busy_q[read_index_1];
    hazard_raw_2    = read_enable_2 & busy_q[read_index_2];
    hazard_waw      = write_enable & busy_q[write_index];
    block_capacity  = long_latency & write_enable & (outstanding_q == MaxOut);
    block_serialize = serialize & (outstanding_q != 3'd0);
    block_state     = (state_q == StDrain);
    // State is already cleared while reset is low; forcing ready keeps that
    // guarantee explicit rather than relying on the reset values.
    issue_ready = ~reset | ~(hazard_raw_1 | hazard_raw_2 | hazard_waw |
                             block_capacity | block_serialize | block_state);
    accept = issue_valid & issue_ready;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d        = busy_q;
    outstanding_d = outstanding_q;
    err_d         = 1'b0;

    // A set and a clear never target the same register: a set needs the
    // destination idle (WAW check), a clear needs it busy.
    do_set   = accept & write_enable & long_latency & (write_index != 5'd0) & ~flush;
    do_clear = complete_valid & busy_q[complete_index] & ~flush;

    if (flush) begin
      busy_d        = '0;
      outstanding_d = '0;
    end else begin
      if (do_clear) begin
        busy_d[complete_index] = 1'b0;
      end
      if (do_set) begin
        busy_d[write_index] = 1'b1;
      end
      outstanding_d = outstanding_q + {2'b00, do_set} - {2'b00, do_clear};
      err_d         = complete_valid & ~busy_q[complete_index];
    end

    busy_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // RUN/DRAIN control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (issue_valid & serialize & (outstanding_q != 3'd0) & ~flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Uses the registered count, so the return to RUN lags the final
        // completion by one edge.
        if ((outstanding_q == 3'd0) | flush) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      busy_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign busy_mask      = busy_q;
  assign outstanding    = outstanding_q;
  assign drain_active   = (state_q == StDrain);
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
//
// Directed bench for issue_scoreboard (MAX_OUTSTANDING = 4). Expected output
// values are queued as each stimulus step is driven and popped/compared at the
// following sample point.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        read_enable_1;
  logic [4:0]  read_index_1;
  logic        read_enable_2;
  logic [4:0]  read_index_2;
  logic        write_enable;
  logic [4:0]  write_index;
  logic        long_latency;
  logic        serialize;
  logic        complete_valid;
  logic [4:0]  complete_index;
  logic        flush;
  logic        issue_ready;
  logic [31:0] busy_mask;
  logic [2:0]  outstanding;
  logic        drain_active;
  logic        err_unexpected;

  issue_scoreboard #(
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .read_enable_1 (read_enable_1),
    .read_index_1  (read_index_1),
    .read_enable_2 (read_enable_2),
    .read_index_2  (read_index_2),
    .write_enable  (write_enable),
    .write_index   (write_index),
    .long_latency  (long_latency),
    .serialize     (serialize),
    .complete_valid(complete_valid),
    .complete_index(complete_index),
    .flush         (flush),
    .issue_ready   (issue_ready),
    .busy_mask     (busy_mask),
    .outstanding   (outstanding),
    .drain_active  (drain_active),
    .err_unexpected(err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string step    = "init";

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Pop every queued expectation and compare it to the named DUT output.
  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      case (e.tag)
        "ready":  obs = {31'd0, issue_ready};
        "busy":   obs = busy_mask;
        "outst":  obs = {29'd0, outstanding};
        "drain":  obs = {31'd0, drain_active};
        "err":    obs = {31'd0, err_unexpected};
        default:  obs = 32'hdead_beef;
      endcase
      n_tests++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s/%s: observed %h expected %h", step, e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    issue_valid    = 1'b0;
    read_enable_1  = 1'b0;
    read_index_1   = 5'd0;
    read_enable_2  = 1'b0;
    read_index_2   = 5'd0;
    write_enable   = 1'b0;
    write_index    = 5'd0;
    long_latency   = 1'b0;
    serialize      = 1'b0;
    complete_valid = 1'b0;
    complete_index = 5'd0;
    flush          = 1'b0;
  endtask

  task automatic long_write(input logic [4:0] idx);
    issue_valid  = 1'b1;
    write_enable = 1'b1;
    write_index  = idx;
    long_latency = 1'b1;
  endtask

  task automatic complete(input logic [4:0] idx);
    complete_valid = 1'b1;
    complete_index = idx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;

    // ---------------- reset state
    step = "reset";
    #2;
    expect_val("busy", 32'h0);
    expect_val("outst", 32'd0);
    expect_val("drain", 32'd0);
    expect_val("err", 32'd0);
    expect_val("ready", 32'd1);
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // ---------------- load x5, dependent add held until after completion
    step = "raw_load";
    tick();
    long_write(5'd5);
    settle();
    expect_val("ready", 32'd1);
    check_all();
    tick();
    expect_val("busy", 32'h20);
    expect_val("outst", 32'd1);
    check_all();

    step = "raw_add";
    idle();
    issue_valid   = 1'b1;
    read_enable_1 = 1'b1;
    read_index_1  = 5'd5;
    read_enable_2 = 1'b1;
    read_index_2  = 5'd1;
    write_enable  = 1'b1;
    write_index   = 5'd6;
    settle();
    expect_val("ready", 32'd0);
    check_all();
    tick();
    expect_val("ready", 32'd0);
    check_all();
    // Completion in the same cycle does not bypass.
    complete(5'd5);
    settle();
    expect_val("ready", 32'd0);
    check_all();
    tick();
    complete_valid = 1'b0;
    settle();
    expect_val("busy", 32'h0);
    expect_val("outst", 32'd0);
    expect_val("ready", 32'd1);
    expect_val("err", 32'd0);
    check_all();
    tick();
    // Short-latency add never marks busy.
    expect_val("busy", 32'h0);
    expect_val("outst", 32'd0);
    check_all();

    // ---------------- capacity: x1..x4 then x7
    step = "capacity";
    idle();
    for (int i = 1; i <= 4; i++) begin
      long_write(5'(i));
      settle();
      expect_val("ready", 32'd1);
      check_all();
      tick();
    end
    expect_val("busy", 32'h1E);
    expect_val("outst", 32'd4);
    check_all();
    long_write(5'd7);
    complete(5'd2);
    settle();
    expect_val("ready", 32'd0);
    check_all();
    tick();
    complete_valid = 1'b0;
    settle();
    expect_val("busy", 32'h1A);
    expect_val("outst", 32'd3);
    expect_val("ready", 32'd1);
    check_all();
    tick();
    expect_val("busy", 32'h9A);
    expect_val("outst", 32'd4);
    check_all();

    // ---------------- flush with three in flight and a completion
    step = "flush";
    idle();
    complete(5'd7);
    tick();
    expect_val("busy", 32'h1A);
    expect_val("outst", 32'd3);
    check_all();
    complete(5'd1);
    flush = 1'b1;
    tick();
    idle();
    expect_val("busy", 32'h0);
    expect_val("outst", 32'd0);
    expect_val("drain", 32'd0);
    expect_val("err", 32'd0);
    check_all();

    // ---------------- simultaneous set/clear, unexpected completions
    step = "set_clear";
    long_write(5'd3);
    tick();
    expect_val("busy", 32'h8);
    expect_val("outst", 32'd1);
    check_all();
    long_write(5'd9);
    complete(5'd3);
    settle();
    expect_val("ready", 32'd1);
    check_all();
    tick();
    expect_val("busy", 32'h200);
    expect_val("outst", 32'd1);
    expect_val("err", 32'd0);
    check_all();

    step = "err_x0";
    idle();
    complete(5'd0);
    tick();
    complete_valid = 1'b0;
    expect_val("err", 32'd1);
    expect_val("busy", 32'h200);
    expect_val("outst", 32'd1);
    check_all();
    tick();
    expect_val("err", 32'd0);
    check_all();

    step = "err_x12";
    complete(5'd12);
    tick();
    complete_valid = 1'b0;
    expect_val("err", 32'd1);
    expect_val("busy", 32'h200);
    expect_val("outst", 32'd1);
    check_all();
    tick();
    expect_val("err", 32'd0);
    check_all();
    complete(5'd9);
    tick();
    idle();
    expect_val("busy", 32'h0);
    expect_val("outst", 32'd0);
    expect_val("err", 32'd0);
    check_all();

    // ---------------- serialize drain
    step = "drain";
    long_write(5'd3);
    tick();
    idle();
    issue_valid = 1'b1;
    serialize   = 1'b1;
    settle();
    expect_val("ready", 32'd0);
    check_all();
    tick();
    expect_val("drain", 32'd1);
    expect_val("ready", 32'd0);
    check_all();
    complete(5'd3);
    tick();
    complete_valid = 1'b0;
    settle();
    expect_val("outst", 32'd0);
    expect_val("drain", 32'd1);
    expect_val("ready", 32'd0);
    check_all();
    tick();
    expect_val("drain", 32'd0);
    expect_val("outst", 32'd0);
    expect_val("ready", 32'd1);
    check_all();
    tick();
    idle();
    expect_val("drain", 32'd0);
    check_all();

    // ---------------- reset mid-drain with two outstanding
    step = "reset_drain";
    long_write(5'd4);
    tick();
    long_write(5'd5);
    tick();
    idle();
    issue_valid = 1'b1;
    serialize   = 1'b1;
    tick();
    expect_val("drain", 32'd1);
    expect_val("outst", 32'd2);
    expect_val("busy", 32'h30);
    check_all();
    #2;
    reset = 1'b0;
    #1;
    expect_val("busy", 32'h0);
    expect_val("outst", 32'd0);
    expect_val("drain", 32'd0);
    expect_val("err", 32'd0);
    expect_val("ready", 32'd1);
    check_all();
    idle();
    @(negedge clk);
    reset = 1'b1;
    long_write(5'd0);
    settle();
    expect_val("ready", 32'd1);
    check_all();
    tick();
    idle();
    expect_val("busy", 32'h0);
    expect_val("outst", 32'd0);
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have the following parameter:
  MAX_OUTSTANDING, default 4, maximum number of in-flight long-latency writes (range 1..7).
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
  clk  in  1  clock, rising edge
  reset  in  1  asynchronous reset, active low
  issue_valid  in  1  decoded instruction present at issue
  read_enable_1  in  1  source 1 used
  read_index_1  in  5  source 1 register
  read_enable_2  in  1  source 2 used
  read_index_2  in  5  source 2 register
  write_enable  in  1  destination written; already 0 for x0
  write_index  in  5  destination register
  long_latency  in  1  result returns later through the completion port (load, mul/div)
  serialize  in  1  instruction requires an empty scoreboard (CSR access, fence)
  complete_valid  in  1  long-latency result written back this cycle
  complete_index  in  5  register written back
  flush  in  1  synchronous pipeline flush
  issue_ready  out  1  issue permitted this cycle
  busy_mask  out  32  registered pending-write bit per register
  outstanding  out  3  registered count of in-flight long-latency writes
  drain_active  out  1  FSM is in DRAIN
  err_unexpected  out  1  one-cycle pulse on a completion to a non-busy register

Function
REQ-004 accept SHALL equal issue_valid & issue_ready.
REQ-005 issue_ready SHALL be combinational from registered state and current inputs, and SHALL be 0 when any of the following holds:
  - RAW: read_enable_1 & busy_mask[read_index_1].
  - RAW: read_enable_2 & busy_mask[read_index_2].
  - WAW: write_enable & busy_mask[write_index].
  - Capacity: long_latency & write_enable & outstanding==MAX_OUTSTANDING.
  - Serialize: serialize & outstanding!=0.
  - State: FSM in DRAIN.
REQ-006 When none of the conditions in REQ-005 holds, issue_ready SHALL be 1, independent of issue_valid.
REQ-007 There SHALL be no same-cycle bypass: a completion clears its busy bit at the clock edge, and a dependent instruction is accepted the cycle after the completion at the earliest.
REQ-008 An accepted instruction with write_enable & long_latency & write_index!=0 SHALL set busy_mask[write_index] and increment outstanding at the next edge.
REQ-009 busy_mask[0] SHALL be 0 at all times, whatever the inputs.
REQ-010 A completion with complete_valid=1 and busy_mask[complete_index]=1 SHALL clear that bit and decrement outstanding at the next edge.
REQ-011 A completion with complete_valid=1 and busy_mask[complete_index]=0 (including index 0) SHALL leave state unchanged and pulse err_unexpected for one cycle, registered.
REQ-012 A simultaneous valid set and valid clear SHALL apply both; outstanding is then unchanged.
REQ-013 outstanding SHALL never wrap; it stays within 0..MAX_OUTSTANDING and always equals popcount(busy_mask).
REQ-014 The FSM SHALL have two states, RUN and DRAIN, with the following transitions:
  - RUN -> DRAIN when issue_valid & serialize & outstanding!=0 & !flush.
  - DRAIN -> RUN at the first edge where outstanding==0 (registered) or flush=1.
  - The serializing instruction SHALL then be accepted in RUN while it is still presented.
REQ-015 flush SHALL, at the next edge, clear busy_mask and outstanding, force RUN, and suppress err_unexpected.
REQ-016 Completions arriving in the flush cycle SHALL be ignored.
REQ-017 issue_ready SHALL still be evaluated from current state during the flush cycle, but accepted writes in that cycle SHALL NOT set busy.
REQ-018 A short-latency write (long_latency=0) SHALL never touch busy_mask or outstanding.

Reset
REQ-019 On reset=0, asynchronously: busy_mask=0, outstanding=0, FSM=RUN, drain_active=0, err_unexpected=0.
REQ-020 issue_ready SHALL be 1 while in reset.
REQ-021 Reset during DRAIN or with writes in flight SHALL discard all state with no completion required.
REQ-022 The first edge after reset rises SHALL behave as RUN with an empty scoreboard.

Verification
REQ-023 Load x5 accepted (long) -> busy_mask=0x20 and outstanding=1 next cycle; add x6,x5,x1 held with issue_ready=0 until the cycle after complete_valid/complete_index=5, then accepted.
REQ-024 Four long writes to x1..x4 then a fifth to x7 -> issue_ready=0 on the fifth; a completion for x2 -> the fifth is accepted the next cycle, outstanding=4.
REQ-025 Load x3 in flight, CSR instruction with serialize=1 presented -> drain_active=1 next cycle and issue_ready=0; completion x3 -> RUN, outstanding=0, CSR accepted the following cycle.
REQ-026 Same-cycle completion of x3 and accepted long write to x9 -> busy_mask=0x200 and outstanding unchanged; completion to x0 or to idle x12 -> err_unexpected pulses once with no state change.
REQ-027 Three writes in flight, flush=1 together with complete_valid for x1 -> busy_mask=0, outstanding=0, RUN, no err_unexpected pulse.
REQ-028 Assert reset mid-DRAIN with 2 writes outstanding -> all outputs at reset values immediately; after release, a long write to x0 is accepted with busy_mask staying 0.
